// File: rtl/sine_pwm_pkg.sv
// Shared types and helpers for the three-phase sine PWM sequencer.
// Holds the state encoding, the phase offset and the clamp/ramp arithmetic.
package sine_pwm_pkg;

  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  function automatic logic [IDX_W-1:0] phase_offset(input int unsigned tbl_len);
    int unsigned third;
    third = tbl_len / 32'd3;
    return third[IDX_W-1:0];
  endfunction

  // Modular add for operands already below len.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b,
                                                input logic [IDX_W-1:0] len);
    logic [IDX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, len}) begin
      sum = sum - {1'b0, len};
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  function automatic logic [31:0] clamp_period(input logic [31:0] p,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
    logic [31:0] r;
    if (p < lo) begin
      r = lo;
    end else if (p > hi) begin
      r = hi;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // One ramp adjustment toward goal; the 33-bit intermediate catches wrap both ways.
  function automatic logic [31:0] ramp_toward(input logic [31:0] cur,
                                              input logic [31:0] goal,
                                              input logic [15:0] step);
    logic [32:0] t;
    logic [31:0] r;
    t = 33'd0;
    if (step == 16'd0) begin
      r = goal;
    end else if (cur > goal) begin
      t = {1'b0, cur} - {17'd0, step};
      if (t[32] || (t[31:0] < goal)) begin
        r = goal;
      end else begin
        r = t[31:0];
      end
    end else if (cur < goal) begin
      t = {1'b0, cur} + {17'd0, step};
      if (t > {1'b0, goal}) begin
        r = goal;
      end else begin
        r = t[31:0];
      end
    end else begin
      r = cur;
    end
    return r;
  endfunction

endpackage

// File: rtl/sine_phase_idx.sv
// Shared sine-table index with wrap-around step, plus the two phase-shifted
// copies; all three are registered and change on the same edge.
module sine_phase_idx
  import sine_pwm_pkg::*;
#(
  parameter int unsigned TBL_LEN = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             dir,
  output logic [IDX_W-1:0] idx_a,
  output logic [IDX_W-1:0] idx_b,
  output logic [IDX_W-1:0] idx_c
);

  localparam logic [IDX_W-1:0] LEN  = 8'(TBL_LEN);
  localparam logic [IDX_W-1:0] OFF  = phase_offset(TBL_LEN);
  localparam logic [IDX_W-1:0] OFF2 = OFF + OFF;

  logic [IDX_W-1:0] idx_a_q, idx_b_q, idx_c_q;
  logic [IDX_W-1:0] idx_a_d, idx_b_d, idx_c_d;

  // Next index and its offset copies.
  always_comb begin
    idx_a_d = idx_a_q;
    if (step) begin
      if (dir) begin
        if (idx_a_q == 8'd0) begin
          idx_a_d = LEN - 8'd1;
        end else begin
          idx_a_d = idx_a_q - 8'd1;
        end
      end else begin
        if (idx_a_q == LEN - 8'd1) begin
          idx_a_d = 8'd0;
        end else begin
          idx_a_d = idx_a_q + 8'd1;
        end
      end
    end else begin
      idx_a_d = idx_a_q;
    end
    idx_b_d = wrap_add(idx_a_d, OFF, LEN);
    idx_c_d = wrap_add(idx_a_d, OFF2, LEN);
  end

  // Index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_a_q <= 8'd0;
      idx_b_q <= OFF;
      idx_c_q <= OFF2;
    end else begin
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      idx_c_q <= idx_c_d;
    end
  end

  assign idx_a = idx_a_q;
  assign idx_b = idx_b_q;
  assign idx_c = idx_c_q;

endmodule

// File: rtl/sine_pwm_ctrl.sv
// Three-phase sine PWM sequencer: ramps the table-step period between standstill
// and the requested speed, and handles enable, disable and direction reversal.
module sine_pwm_ctrl
  import sine_pwm_pkg::*;
#(
  parameter int unsigned TBL_LEN      = 30,
  parameter logic [31:0] START_PERIOD = 32'd65535,
  parameter logic [31:0] MIN_PERIOD   = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        dir,
  input  logic [31:0] target_period,
  input  logic [15:0] ramp_div,
  input  logic [15:0] ramp_step,
  output logic [7:0]  idx_a,
  output logic [7:0]  idx_b,
  output logic [7:0]  idx_c,
  output logic        step_strobe,
  output logic [31:0] cur_period,
  output logic        running,
  output logic [1:0]  state_o
);

  state_e      state_q, state_d;
  logic [31:0] cur_period_q, cur_period_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [15:0] ramp_cnt_q, ramp_cnt_d;
  logic        dir_q, dir_d;
  logic        strobe_q, strobe_d;
  logic        running_q, running_d;

  logic [31:0] tgt_s, goal_s;
  logic        active_s, ramping_s, step_hit_s, ramp_hit_s;

  // Timer decodes; the step compare uses the period before this cycle's ramp update.
  always_comb begin
    tgt_s      = clamp_period(target_period, MIN_PERIOD, START_PERIOD);
    active_s   = (state_q != ST_IDLE);
    ramping_s  = (state_q == ST_RAMP) || (state_q == ST_STOP);
    goal_s     = (state_q == ST_STOP) ? START_PERIOD : tgt_s;
    step_hit_s = active_s && (step_cnt_q >= (cur_period_q - 32'd1));
    ramp_hit_s = ramping_s && (ramp_cnt_q >= ramp_div);
  end

  // Next-state, timers and period ramp.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;

    if (active_s) begin
      step_cnt_d = step_hit_s ? 32'd0 : (step_cnt_q + 32'd1);
    end else begin
      step_cnt_d = step_cnt_q;
    end

    if (ramp_hit_s) begin
      ramp_cnt_d   = 16'd0;
      cur_period_d = ramp_toward(cur_period_q, goal_s, ramp_step);
    end else if (ramping_s) begin
      ramp_cnt_d   = ramp_cnt_q + 16'd1;
      cur_period_d = cur_period_q;
    end else begin
      ramp_cnt_d   = 16'd0;
      cur_period_d = cur_period_q;
    end

    // Direction change outranks disable, which outranks a target change.
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          dir_d        = dir;
          cur_period_d = START_PERIOD;
          state_d      = ST_RAMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (dir != dir_q) begin
          state_d = ST_STOP;
        end else if (!enable) begin
          state_d = ST_STOP;
        end else if (cur_period_q == tgt_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RAMP;
        end
      end
      ST_RUN: begin
        if (dir != dir_q) begin
          state_d = ST_STOP;
        end else if (!enable) begin
          state_d = ST_STOP;
        end else if (cur_period_q != tgt_s) begin
          state_d = ST_RAMP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STOP: begin
        if (cur_period_q == START_PERIOD) begin
          if (enable && (dir != dir_q)) begin
            dir_d   = dir;
            state_d = ST_RAMP;
          end else if (!enable) begin
            state_d    = ST_IDLE;
            step_cnt_d = 32'd0;
            ramp_cnt_d = 16'd0;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    strobe_d  = step_hit_s;
    running_d = (state_d != ST_IDLE);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_period_q <= START_PERIOD;
      step_cnt_q   <= 32'd0;
      ramp_cnt_q   <= 16'd0;
      dir_q        <= 1'b0;
      strobe_q     <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_period_q <= cur_period_d;
      step_cnt_q   <= step_cnt_d;
      ramp_cnt_q   <= ramp_cnt_d;
      dir_q        <= dir_d;
      strobe_q     <= strobe_d;
      running_q    <= running_d;
    end
  end

  sine_phase_idx #(
    .TBL_LEN(TBL_LEN)
  ) u_phase_idx (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step_hit_s),
    .dir  (dir_q),
    .idx_a(idx_a),
    .idx_b(idx_b),
    .idx_c(idx_c)
  );

  assign step_strobe = strobe_q;
  assign cur_period  = cur_period_q;
  assign running     = running_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_sine_pwm_ctrl.sv
// Self-checking bench for sine_pwm_ctrl with a shortened START_PERIOD of 100.
module tb_sine_pwm_ctrl;

  localparam logic [31:0] SP = 32'd100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        dir;
  logic [31:0] target_period;
  logic [15:0] ramp_div;
  logic [15:0] ramp_step;
  logic [7:0]  idx_a, idx_b, idx_c;
  logic        step_strobe;
  logic [31:0] cur_period;
  logic        running;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  sine_pwm_ctrl #(
    .TBL_LEN     (30),
    .START_PERIOD(SP),
    .MIN_PERIOD  (32'd2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .dir          (dir),
    .target_period(target_period),
    .ramp_div     (ramp_div),
    .ramp_step    (ramp_step),
    .idx_a        (idx_a),
    .idx_b        (idx_b),
    .idx_c        (idx_c),
    .step_strobe  (step_strobe),
    .cur_period   (cur_period),
    .running      (running),
    .state_o      (state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        en;
    logic        dr;
    logic [31:0] tgt;
    int          ncyc;
    logic [1:0]  st;
    logic [31:0] per;
    string       name;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] per;
    string       name;
  } exp_t;

  vec_t        vecs[11];
  exp_t        sb[$];
  logic [31:0] per_q[$];

  function automatic vec_t mk_vec(input logic en, input logic dr, input logic [31:0] tgt,
                                  input int ncyc, input logic [1:0] st,
                                  input logic [31:0] per, input string name);
    vec_t v;
    v.en = en; v.dr = dr; v.tgt = tgt; v.ncyc = ncyc;
    v.st = st; v.per = per; v.name = name;
    return v;
  endfunction

  function automatic logic [7:0] add30(input logic [7:0] a, input int b);
    int s;
    s = int'(a) + b;
    return 8'(s % 30);
  endfunction

  function automatic logic [7:0] next_idx(input logic [7:0] a, input logic d);
    logic [7:0] r;
    if (d) r = (a == 8'd0) ? 8'd29 : a - 8'd1;
    else   r = (a == 8'd29) ? 8'd0 : a + 8'd1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired before the expected event", name);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string name, input int bound, output int n);
    n = 0;
    do begin
      run(1);
      n++;
    end while (step_strobe !== 1'b1 && n < bound);
    if (step_strobe !== 1'b1) timeout(name);
  endtask

  task automatic wait_state(input string name, input logic [1:0] st, input int bound);
    int n;
    n = 0;
    while (state_o !== st && n < bound) begin
      run(1);
      n++;
    end
    if (state_o !== st) timeout(name);
  endtask

  task automatic wait_idx(input string name, input logic [7:0] v, input int bound);
    int n;
    n = 0;
    while (idx_a !== v && n < bound) begin
      run(1);
      n++;
    end
    if (idx_a !== v) timeout(name);
  endtask

  task automatic wait_period(input string name, input logic [31:0] v, input int bound);
    int n;
    n = 0;
    while (cur_period !== v && n < bound) begin
      run(1);
      n++;
    end
    if (cur_period !== v) timeout(name);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      enable        = vecs[i].en;
      dir           = vecs[i].dr;
      target_period = vecs[i].tgt;
      sb.push_back('{vecs[i].st, vecs[i].per, vecs[i].name});
      run(vecs[i].ncyc);
      e = sb.pop_front();
      check({e.name, "_state"}, 32'(state_o), 32'(e.st));
      check({e.name, "_period"}, cur_period, e.per);
      check({e.name, "_running"}, 32'(running), 32'(e.st != 2'd0));
    end
  endtask

  // Continuous model of phase spacing and of index motion per latched direction.
  logic [7:0] m_prev_idx;
  logic [1:0] m_prev_state;
  logic       m_dir_seen;
  logic       m_dir;
  logic       m_valid = 1'b0;
  int         phase_err = 0;
  int         dir_err = 0;
  int         strobe_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_dir   <= 1'b0;
    end else begin
      if (idx_b !== add30(idx_a, 10) || idx_c !== add30(idx_a, 20))
        phase_err <= phase_err + 1;
      if (step_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
      if (m_valid) begin
        if (step_strobe === 1'b1) begin
          if (idx_a !== next_idx(m_prev_idx, m_dir)) dir_err <= dir_err + 1;
        end else if (idx_a !== m_prev_idx) begin
          dir_err <= dir_err + 1;
        end
        if ((m_prev_state == 2'd0 || m_prev_state == 2'd3) && state_o == 2'd1)
          m_dir <= m_dir_seen;
      end
      m_valid      <= 1'b1;
      m_prev_idx   <= idx_a;
      m_prev_state <= state_o;
      m_dir_seen   <= dir;
    end
  end

  initial begin
    int n;
    int s0;
    logic [31:0] last_per;
    logic [31:0] ep;
    logic [7:0] fa, fb, fc;
    bit done;

    vecs[0]  = mk_vec(1'b1, 1'b0, 32'd40, 1,  2'd1, 32'd100, "accel_start");
    vecs[1]  = mk_vec(1'b1, 1'b0, 32'd40, 9,  2'd1, 32'd100, "accel_hold");
    vecs[2]  = mk_vec(1'b1, 1'b0, 32'd40, 1,  2'd1, 32'd80,  "accel_80");
    vecs[3]  = mk_vec(1'b1, 1'b0, 32'd40, 10, 2'd1, 32'd60,  "accel_60");
    vecs[4]  = mk_vec(1'b1, 1'b0, 32'd40, 10, 2'd1, 32'd40,  "accel_40");
    vecs[5]  = mk_vec(1'b1, 1'b0, 32'd40, 1,  2'd2, 32'd40,  "accel_run");
    vecs[6]  = mk_vec(1'b1, 1'b1, 32'd40, 1,  2'd3, 32'd40,  "rev_stop");
    vecs[7]  = mk_vec(1'b1, 1'b1, 32'd40, 10, 2'd3, 32'd60,  "rev_60");
    vecs[8]  = mk_vec(1'b1, 1'b1, 32'd40, 10, 2'd3, 32'd80,  "rev_80");
    vecs[9]  = mk_vec(1'b1, 1'b1, 32'd40, 10, 2'd3, 32'd100, "rev_100");
    vecs[10] = mk_vec(1'b1, 1'b1, 32'd40, 1,  2'd1, 32'd100, "rev_ramp");

    rst_n = 1'b0; enable = 1'b0; dir = 1'b0;
    target_period = 32'd40; ramp_div = 16'd9; ramp_step = 16'd20;
    run(3);
    rst_n = 1'b1;
    s0 = strobe_cnt;
    run(1000);
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_idx_a", 32'(idx_a), 32'd0);
    check("idle_idx_b", 32'(idx_b), 32'd10);
    check("idle_idx_c", 32'(idx_c), 32'd20);
    check("idle_period", cur_period, 32'd100);
    check("idle_running", 32'(running), 32'd0);
    check("idle_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Acceleration 100 -> 80 -> 60 -> 40, then RUN with 40-cycle steps.
    apply_vecs(0, 5);
    wait_strobe("run_first_strobe", 60, n);
    check("run_first_idx_a", 32'(idx_a), 32'd1);
    check("run_first_idx_b", 32'(idx_b), 32'd11);
    wait_strobe("run_strobe2", 60, n);
    check("run_spacing", 32'(n), 32'd40);

    // Forward wrap 29 -> 0.
    wait_idx("wrap_reach29", 8'd29, 1500);
    check("wrap_pre_b", 32'(idx_b), 32'd9);
    check("wrap_pre_c", 32'(idx_c), 32'd19);
    wait_strobe("wrap_strobe", 60, n);
    check("wrap_idx_a", 32'(idx_a), 32'd0);
    check("wrap_idx_b", 32'(idx_b), 32'd10);
    check("wrap_idx_c", 32'(idx_c), 32'd20);
    check("wrap_spacing", 32'(n), 32'd40);

    // Reversal: decelerate to START_PERIOD, relatch, then count down through 0 -> 29.
    apply_vecs(6, 10);
    wait_state("rev_to_run", 2'd2, 500);
    check("rev_run_period", cur_period, 32'd40);
    wait_idx("rev_reach0", 8'd0, 2000);
    wait_strobe("rev_wrap_strobe", 60, n);
    check("rev_wrap_a", 32'(idx_a), 32'd29);
    check("rev_wrap_b", 32'(idx_b), 32'd9);
    check("rev_wrap_c", 32'(idx_c), 32'd19);

    // Clamp low.
    target_period = 32'd0;
    run(1);
    check("clamp_lo_ramp", 32'(state_o), 32'd1);
    wait_state("clamp_lo_run", 2'd2, 200);
    check("clamp_lo_period", cur_period, 32'd2);
    wait_strobe("clamp_lo_sync", 10, n);
    wait_strobe("clamp_lo_strobe", 10, n);
    check("clamp_lo_spacing", 32'(n), 32'd2);

    // Clamp high.
    target_period = 32'hFFFF_FFFF;
    run(1);
    check("clamp_hi_ramp", 32'(state_o), 32'd1);
    wait_state("clamp_hi_run", 2'd2, 200);
    check("clamp_hi_period", cur_period, 32'd100);
    wait_strobe("clamp_hi_sync", 200, n);
    wait_strobe("clamp_hi_strobe", 200, n);
    check("clamp_hi_spacing", 32'(n), 32'd100);

    // Disable mid-RAMP at 60: STOP climbs 80, 100, then IDLE.
    target_period = 32'd40;
    run(1);
    check("dis_ramp", 32'(state_o), 32'd1);
    wait_period("dis_reach60", 32'd60, 100);
    enable = 1'b0;
    per_q.push_back(32'd80);
    per_q.push_back(32'd100);
    last_per = cur_period;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      run(1);
      if (cur_period !== last_per) begin
        if (per_q.size() == 0) begin
          check("dis_extra_change", cur_period, last_per);
        end else begin
          ep = per_q.pop_front();
          check("dis_period_step", cur_period, ep);
        end
        last_per = cur_period;
      end
      if (state_o == 2'd0) done = 1'b1;
    end
    if (!done) timeout("dis_to_idle");
    check("dis_state", 32'(state_o), 32'd0);
    check("dis_running", 32'(running), 32'd0);
    check("dis_sb_left", 32'(per_q.size()), 32'd0);
    fa = idx_a; fb = idx_b; fc = idx_c;
    s0 = strobe_cnt;
    run(300);
    check("freeze_idx_a", 32'(idx_a), 32'(fa));
    check("freeze_idx_b", 32'(idx_b), 32'(fb));
    check("freeze_idx_c", 32'(idx_c), 32'(fc));
    check("freeze_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Asynchronous reset in RUN, right after a strobe.
    target_period = 32'd100;
    enable = 1'b1;
    wait_state("rst_run", 2'd2, 20);
    wait_strobe("rst_strobe", 150, n);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_idx_a", 32'(idx_a), 32'd0);
    check("arst_idx_b", 32'(idx_b), 32'd10);
    check("arst_idx_c", 32'(idx_c), 32'd20);
    check("arst_strobe", 32'(step_strobe), 32'd0);
    check("arst_period", cur_period, 32'd100);
    check("arst_running", 32'(running), 32'd0);
    enable = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(1);
    check("release_strobe", 32'(step_strobe), 32'd0);
    check("release_state", 32'(state_o), 32'd0);

    check("phase_coherence_errors", 32'(phase_err), 32'd0);
    check("index_motion_errors", 32'(dir_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
